pixel_stream_source: RTL and testbench



---
 rtl/pixel_stream_if.sv | 10 +
 rtl/pixel_stream_source.sv | 107 ++++++++++
 tb/tb_pixel_stream_source.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/pixel_stream_if.sv
// pixel_stream_if: AXI-Stream RGB pixel bus with start-of-frame and end-of-line sideband
interface pixel_stream_if #(parameter int DATA_WIDTH = 8);
  logic [3*DATA_WIDTH-1:0] tdata;
  logic tvalid;
  logic tready;
  logic tuser;
  logic tlast;
  modport master (output tdata, tvalid, tuser, tlast, input tready);
  modport slave (input tdata, tvalid, tuser, tlast, output tready);
endinterface

// File: rtl/pixel_stream_source.sv
// pixel_stream_source: raster-order frame-buffer reader feeding an RGB AXI-Stream through a 2-entry skid buffer
module pixel_stream_source #(
  parameter int WIDTH      = 640,
  parameter int HEIGHT     = 480,
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 19
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    i_enable,
  input  logic                    i_start,
  output logic                    o_busy,
  output logic                    o_done,
  output logic                    o_frame_start,
  output logic                    o_mem_rd_en,
  output logic [ADDR_WIDTH-1:0]   o_mem_addr,
  input  logic [3*DATA_WIDTH-1:0] i_mem_rd_data,
  pixel_stream_if.master          m_axis
);
  localparam int PW = 3*DATA_WIDTH;
  localparam int XW = WIDTH > 1 ? $clog2(WIDTH) : 1;
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(WIDTH*HEIGHT-1);
  typedef enum logic [1:0] {IDLE, SOF, READ, DRAIN} state_t;
  state_t r_state, w_next;
  logic [XW-1:0] r_x;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic r_inflight, r_if_user, r_if_last, r_done;
  logic [1:0] r_fill;
  logic [PW+1:0] r_buf0, r_buf1;
  logic w_pop, w_push, w_rd_en, w_last_issue, w_drain_done;
  logic [1:0] w_occ, w_fill_pop;
  logic [PW+1:0] w_in;
  assign w_pop        = m_axis.tvalid && m_axis.tready;
  assign w_push       = r_inflight;
  assign w_in         = {i_mem_rd_data, r_if_user, r_if_last};
  assign w_occ        = r_fill + {1'b0, r_inflight};
  assign w_fill_pop   = r_fill - {1'b0, w_pop};
  assign w_rd_en      = r_state == READ && i_enable && (w_occ < 2'd2 || (w_occ == 2'd2 && w_pop));
  assign w_last_issue = w_rd_en && r_addr == LAST_ADDR;
  assign w_drain_done = r_state == DRAIN && !r_inflight && (r_fill == 2'd0 || (r_fill == 2'd1 && w_pop));
  assign o_busy        = r_state != IDLE;
  assign o_done        = r_done;
  assign o_frame_start = r_state == SOF;
  assign o_mem_rd_en   = w_rd_en;
  assign o_mem_addr    = r_addr;
  assign m_axis.tvalid = r_fill != 2'd0;
  assign m_axis.tdata  = r_buf0[PW+1:2];
  assign m_axis.tuser  = r_buf0[1];
  assign m_axis.tlast  = r_buf0[0];
  // next state: a start coinciding with the done pulse is not accepted
  always_comb begin
    w_next = r_state == IDLE  ? ((i_start && !r_done) ? SOF : IDLE) :
             r_state == SOF   ? READ :
             r_state == READ  ? (w_last_issue ? DRAIN : READ) :
                                (w_drain_done ? IDLE : DRAIN);
  end
  // state register and done pulse
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_next;
      r_done  <= w_drain_done;
    end
  end
  // raster read counter; holds on the last pixel instead of wrapping
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_x    <= '0;
      r_addr <= '0;
    end else if (r_state == SOF) begin
      r_x    <= '0;
      r_addr <= '0;
    end else if (w_rd_en && !w_last_issue) begin
      r_x    <= r_x == XW'(WIDTH-1) ? '0 : r_x + 1'b1;
      r_addr <= r_addr + 1'b1;
    end
  end
  // sideband for the read in flight, taken from the address at issue time
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_inflight <= 1'b0;
      r_if_user  <= 1'b0;
      r_if_last  <= 1'b0;
    end else begin
      r_inflight <= w_rd_en;
      if (w_rd_en) begin
        r_if_user <= r_addr == '0;
        r_if_last <= r_x == XW'(WIDTH-1);
      end
    end
  end
  // 2-entry buffer: head in r_buf0 drives the stream, returned data lands behind what remains after a pop
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_fill <= 2'd0;
      r_buf0 <= '0;
      r_buf1 <= '0;
    end else begin
      r_fill <= w_fill_pop + {1'b0, w_push};
      if (w_pop) r_buf0 <= r_buf1;
      if (w_push && w_fill_pop == 2'd0) r_buf0 <= w_in;
      if (w_push && w_fill_pop == 2'd1) r_buf1 <= w_in;
    end
  end
endmodule

// File: tb/tb_pixel_stream_source.sv
// tb_pixel_stream_source: directed checks of frame timing, back-pressure, enable pause, start filtering and reset
module tb_pixel_stream_source;
  localparam int W = 4, H = 2, DW = 8, AW = 3, N = W*H;
  logic clk = 1'b0, rst = 1'b1, enable = 1'b0, start = 1'b0;
  logic busy, done, fs, rd_en;
  logic [AW-1:0] addr;
  logic [3*DW-1:0] rd_data = '0;
  pixel_stream_if #(.DATA_WIDTH(DW)) axis ();
  pixel_stream_source #(.WIDTH(W), .HEIGHT(H), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst(rst), .i_enable(enable), .i_start(start),
    .o_busy(busy), .o_done(done), .o_frame_start(fs), .o_mem_rd_en(rd_en),
    .o_mem_addr(addr), .i_mem_rd_data(rd_data), .m_axis(axis)
  );
  always #5 clk = ~clk;
  always @(posedge clk) if (rd_en) rd_data <= {8'(addr), 8'(addr) + 8'd1, 8'(addr) + 8'd2};
  int checks = 0, fails = 0;
  int cyc_n = 0, s, rd_cnt, fs_cnt, fs_cyc, done_cnt, done_cyc, rd_first, max_out, stall_viol, rd_dis, lo, rd20, win_beats;
  logic busy_at_fs, busy_at_done, prev_stall;
  logic [3*DW+1:0] prev_beat;
  logic [3*DW-1:0] bd[$];
  logic bu[$], bl[$];
  int bc[$];
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic clear_rec();
    rd_cnt = 0; fs_cnt = 0; fs_cyc = 0; done_cnt = 0; done_cyc = 0; rd_first = 0;
    max_out = 0; stall_viol = 0; rd_dis = 0; lo = 0; rd20 = 0; win_beats = 0;
    busy_at_fs = 1'b0; busy_at_done = 1'b1; prev_stall = 1'b0; prev_beat = '0;
    bd.delete(); bu.delete(); bl.delete(); bc.delete();
  endtask
  task automatic step(input logic rdy, input logic en, input logic st);
    @(posedge clk);
    #1;
    axis.tready = rdy; enable = en; start = st;
    #1;
    cyc_n++;
    if (rd_en) begin
      if (rd_cnt == 0) rd_first = cyc_n;
      rd_cnt++;
      if (!enable) rd_dis++;
    end
    if (axis.tvalid && axis.tready) begin
      bd.push_back(axis.tdata); bu.push_back(axis.tuser); bl.push_back(axis.tlast); bc.push_back(cyc_n);
    end
    if (rd_en && rd_cnt - bd.size() > max_out) max_out = rd_cnt - bd.size();
    if (prev_stall && {axis.tdata, axis.tuser, axis.tlast} !== prev_beat) stall_viol++;
    prev_stall = axis.tvalid && !axis.tready;
    prev_beat = {axis.tdata, axis.tuser, axis.tlast};
    if (fs) begin fs_cnt++; fs_cyc = cyc_n; busy_at_fs = busy; end
    if (done) begin done_cnt++; done_cyc = cyc_n; busy_at_done = busy; end
  endtask
  // mode 0: ready; 1: ready 1,0,0,1; 2: ready low 20 cycles; 3: enable low 5 cycles after beat 2;
  // 4: extra starts while busy and in the done cycle; 5: stop after beat 3
  task automatic run_frame(input int mode);
    clear_rec();
    step(1'b1, 1'b1, 1'b1);
    s = cyc_n;
    for (int i = 0; i < 200 && done_cnt == 0 && !(mode == 5 && bd.size() >= 4); i++) begin
      int j;
      logic r, e, st;
      j = cyc_n + 1 - s;
      r = mode == 1 ? ((j-1) % 4 == 0 || (j-1) % 4 == 3) : mode == 2 ? (j > 20) : 1'b1;
      if (mode == 3 && lo == 0 && bd.size() >= 3) lo = cyc_n + 1;
      e = !(mode == 3 && lo != 0 && cyc_n + 1 >= lo && cyc_n + 1 < lo + 5);
      st = mode == 4 && (j == 6 || j == 12);
      step(r, e, st);
      if (mode == 2 && j == 20) rd20 = rd_cnt;
      if (mode == 3 && lo != 0 && cyc_n == lo + 4) win_beats = bd.size();
    end
  endtask
  task automatic check_frame(input string tag);
    chk($sformatf("%s_beats", tag), bd.size(), N);
    for (int i = 0; i < N && i < bd.size(); i++) begin
      chk($sformatf("%s_data%0d", tag, i), bd[i], {8'(i), 8'(i+1), 8'(i+2)});
      chk($sformatf("%s_user%0d", tag, i), bu[i], i == 0);
      chk($sformatf("%s_last%0d", tag, i), bl[i], i % W == W-1);
    end
  endtask
  task automatic check_reset(input string tag);
    chk($sformatf("%s_ctl", tag), {busy, done, fs, rd_en, axis.tvalid, axis.tuser, axis.tlast}, 0);
    chk($sformatf("%s_addr", tag), addr, 0);
    chk($sformatf("%s_data", tag), axis.tdata, 0);
  endtask
  initial begin
    axis.tready = 1'b1;
    clear_rec();
    repeat (3) @(posedge clk);
    #1;
    check_reset("reset");
    rst = 1'b0;
    repeat (3) step(1'b1, 1'b1, 1'b0);
    run_frame(0);
    check_frame("A");
    chk("A_fs_cnt", fs_cnt, 1);
    chk("A_fs_cyc", fs_cyc - s, 1);
    chk("A_busy_at_fs", busy_at_fs, 1);
    chk("A_rd_first", rd_first - s, 2);
    chk("A_first_beat", bc[0] - s, 4);
    chk("A_last_beat", bc[N-1] - s, 3 + N);
    chk("A_done_cyc", done_cyc - s, 4 + N);
    chk("A_done_cnt", done_cnt, 1);
    chk("A_busy_at_done", busy_at_done, 0);
    repeat (2) step(1'b1, 1'b1, 1'b0);
    run_frame(1);
    check_frame("B");
    chk("B_stall_stable", stall_viol, 0);
    chk("B_max_out", max_out <= 2, 1);
    repeat (2) step(1'b1, 1'b1, 1'b0);
    run_frame(2);
    check_frame("C");
    chk("C_reads_stalled", rd20, 2);
    chk("C_burst", bc[N-1] - bc[2], N - 3);
    chk("C_max_out", max_out <= 2, 1);
    repeat (2) step(1'b1, 1'b1, 1'b0);
    run_frame(3);
    check_frame("D");
    chk("D_rd_while_disabled", rd_dis, 0);
    chk("D_window_drain", win_beats, 5);
    repeat (2) step(1'b1, 1'b1, 1'b0);
    run_frame(4);
    chk("E_fs_cnt_first", fs_cnt, 1);
    chk("E_done_cyc", done_cyc - s, 4 + N);
    step(1'b1, 1'b1, 1'b1);
    chk("E_busy_after_done", busy, 0);
    step(1'b1, 1'b1, 1'b0);
    chk("E_fs_cnt_second", fs_cnt, 2);
    chk("E_fs_cyc_second", fs_cyc - s, 6 + N);
    for (int i = 0; i < 40 && done_cnt < 2; i++) step(1'b1, 1'b1, 1'b0);
    chk("E_done_cnt", done_cnt, 2);
    chk("E_beats", bd.size(), 2*N);
    repeat (2) step(1'b1, 1'b1, 1'b0);
    run_frame(5);
    chk("F_beats_before_rst", bd.size(), 4);
    rst = 1'b1;
    #1;
    check_reset("F_async");
    repeat (2) step(1'b1, 1'b1, 1'b0);
    rst = 1'b0;
    repeat (3) step(1'b1, 1'b1, 1'b0);
    chk("F_no_done", done_cnt, 0);
    run_frame(0);
    check_frame("F2");
    chk("F2_first_beat", bc[0] - s, 4);
    chk("F2_done_cyc", done_cyc - s, 4 + N);
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule
